// File: rtl/cam_lru.sv
// Parametrised key/value CAM with one-cycle read response, in-place update,
// true-LRU replacement when full, synchronous flush and occupancy count.
module cam_lru #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic                       rw_n,
  input  logic [KEY_W-1:0]           key,
  input  logic [VAL_W-1:0]           val_i,
  input  logic                       flush,
  output logic                       valid_o,
  output logic                       hit_o,
  output logic [VAL_W-1:0]           val_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             r_valid [DEPTH];
  logic [KEY_W-1:0] r_key   [DEPTH];
  logic [VAL_W-1:0] r_val   [DEPTH];
  logic [AW-1:0]    r_age   [DEPTH];
  logic [CW-1:0]    r_count;

  logic             r_valid_o;
  logic             r_hit_o;
  logic [VAL_W-1:0] r_val_o;

  logic             w_hit;
  logic [AW-1:0]    w_hit_idx;
  logic             w_has_free;
  logic [AW-1:0]    w_free_idx;
  logic [AW-1:0]    w_lru_idx;
  logic             w_wr;
  logic             w_rd;
  logic             w_touch;
  logic             w_alloc;
  logic [AW-1:0]    w_tgt;

  // A request coinciding with flush is dropped entirely.
  assign w_wr = valid_i & ~rw_n & ~flush;
  assign w_rd = valid_i &  rw_n & ~flush;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_lru_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_key[i] == key)) begin
        w_hit     = 1'b1;
        w_hit_idx = AW'(i);
      end
      if (!r_valid[i] && !w_has_free) begin
        w_has_free = 1'b1;
        w_free_idx = AW'(i);
      end
      if (r_age[i] == AW'(DEPTH - 1)) begin
        w_lru_idx = AW'(i);
      end
    end
  end

  always_comb begin
    w_alloc = w_wr & ~w_hit & w_has_free;
    w_touch = w_wr | (w_rd & w_hit);
    if (!w_wr || w_hit) begin
      w_tgt = w_hit_idx;
    end else if (w_has_free) begin
      w_tgt = w_free_idx;
    end else begin
      w_tgt = w_lru_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_key[i]   <= '0;
        r_val[i]   <= '0;
        r_age[i]   <= AW'(i);
      end
      r_count <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_age[i]   <= AW'(i);
      end
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_valid[w_tgt] <= 1'b1;
        r_key[w_tgt]   <= key;
        r_val[w_tgt]   <= val_i;
      end
      if (w_alloc) begin
        r_count <= r_count + CW'(1);
      end
      // Touch: entries younger than the target age by one, target becomes MRU.
      if (w_touch) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (AW'(i) == w_tgt) begin
            r_age[i] <= '0;
          end else if (r_age[i] < r_age[w_tgt]) begin
            r_age[i] <= r_age[i] + AW'(1);
          end
        end
      end
    end
  end

  // Response register: hit/val hold their last value between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_o <= 1'b0;
      r_hit_o   <= 1'b0;
      r_val_o   <= '0;
    end else begin
      r_valid_o <= w_rd;
      if (w_rd) begin
        r_hit_o <= w_hit;
        r_val_o <= w_hit ? r_val[w_hit_idx] : '0;
      end
    end
  end

  assign valid_o = r_valid_o;
  assign hit_o   = r_hit_o;
  assign val_o   = r_val_o;
  assign count_o = r_count;

endmodule

// File: tb/tb_cam_lru.sv
// Directed bench for cam_lru: hit/miss, update, LRU eviction, flush and reset.
module tb_cam_lru;

  localparam int KEY_W = 16;
  localparam int VAL_W = 16;
  localparam int DEPTH = 8;

  logic                   clk;
  logic                   reset;
  logic                   valid_i;
  logic                   rw_n;
  logic [KEY_W-1:0]       key;
  logic [VAL_W-1:0]       val_i;
  logic                   flush;
  logic                   valid_o;
  logic                   hit_o;
  logic [VAL_W-1:0]       val_o;
  logic [$clog2(DEPTH):0] count_o;

  int total;
  int bad;

  cam_lru #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .valid_i(valid_i),
    .rw_n   (rw_n),
    .key    (key),
    .val_i  (val_i),
    .flush  (flush),
    .valid_o(valid_o),
    .hit_o  (hit_o),
    .val_o  (val_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request driven just after an edge; returns 1 time unit after the next edge.
  task automatic do_write(input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] v);
    valid_i = 1'b1; rw_n = 1'b0; key = k; val_i = v;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("wr_no_valid_o", 32'(valid_o), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [KEY_W-1:0] k,
                         input logic exp_hit, input logic [VAL_W-1:0] exp_val);
    valid_i = 1'b1; rw_n = 1'b1; key = k;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_hit"},   32'(hit_o),   32'(exp_hit));
    check({tag, "_val"},   32'(val_o),   32'(exp_val));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; valid_i = 1'b0; rw_n = 1'b1; key = '0; val_i = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_hit_o",   32'(hit_o),   32'd0);
    check("rst_val_o",   32'(val_o),   32'd0);
    check("rst_count",   32'(count_o), 32'd0);

    // Read on empty CAM misses; response is a single-cycle pulse
    do_read("empty_rd", 16'h0001, 1'b0, 16'h0000);
    check("empty_count", 32'(count_o), 32'd0);
    idle_cycle();
    check("pulse_end", 32'(valid_o), 32'd0);

    // Write then immediate read
    do_write(16'h0010, 16'hAAAA);
    check("wr1_count", 32'(count_o), 32'd1);
    do_read("rd_aaaa", 16'h0010, 1'b1, 16'hAAAA);

    // In-place update
    do_write(16'h0010, 16'hBBBB);
    do_read("rd_bbbb", 16'h0010, 1'b1, 16'hBBBB);
    check("upd_count", 32'(count_o), 32'd1);

    // Flush alone, then fill all 8 entries
    flush = 1'b1; idle_cycle(); flush = 1'b0;
    check("flush0_count", 32'(count_o), 32'd0);
    for (int i = 0; i < 8; i++) do_write(16'(16'h0010 + i), 16'(16'h0100 + i));
    check("full_count", 32'(count_o), 32'd8);
    do_read("touch_10", 16'h0010, 1'b1, 16'h0100);
    do_write(16'h0018, 16'h0108);
    check("evict_count", 32'(count_o), 32'd8);
    do_read("evicted_11", 16'h0011, 1'b0, 16'h0000);
    do_read("kept_10",    16'h0010, 1'b1, 16'h0100);
    do_read("new_18",     16'h0018, 1'b1, 16'h0108);
    idle_cycle();
    check("hold_valid", 32'(valid_o), 32'd0);
    check("hold_hit",   32'(hit_o),   32'd1);
    check("hold_val",   32'(val_o),   32'h0108);
    // LRU now is key 0x12; update of an existing key while full must not evict
    do_write(16'h0017, 16'h0777);
    do_read("upd_full_17", 16'h0017, 1'b1, 16'h0777);
    do_write(16'h0019, 16'h0109);
    do_read("evicted_12", 16'h0012, 1'b0, 16'h0000);
    do_read("kept_13",    16'h0013, 1'b1, 16'h0103);
    check("full_count2", 32'(count_o), 32'd8);

    // Flush with simultaneous write drops the write
    flush = 1'b1; idle_cycle(); flush = 1'b0;
    do_write(16'h0030, 16'h0001);
    do_write(16'h0031, 16'h0002);
    do_write(16'h0032, 16'h0003);
    check("fill3_count", 32'(count_o), 32'd3);
    flush = 1'b1; valid_i = 1'b1; rw_n = 1'b0; key = 16'h0020; val_i = 16'h0001;
    @(posedge clk); #1;
    flush = 1'b0; valid_i = 1'b0;
    check("flushwr_count", 32'(count_o), 32'd0);
    check("flushwr_vo",    32'(valid_o), 32'd0);
    do_read("flushed_20", 16'h0020, 1'b0, 16'h0000);
    do_read("flushed_30", 16'h0030, 1'b0, 16'h0000);

    // Read alongside flush is dropped; pending response survives flush
    flush = 1'b1; valid_i = 1'b1; rw_n = 1'b1; key = 16'h0030;
    @(posedge clk); #1;
    flush = 1'b0; valid_i = 1'b0;
    check("flushrd_vo", 32'(valid_o), 32'd0);
    do_write(16'h0040, 16'h0007);
    do_read("pend_40", 16'h0040, 1'b1, 16'h0007);
    flush = 1'b1; idle_cycle(); flush = 1'b0;
    check("pend_flush_vo",    32'(valid_o), 32'd0);
    check("pend_flush_count", 32'(count_o), 32'd0);

    // Asynchronous reset during a response cycle
    do_write(16'h0010, 16'h0100);
    do_read("pre_rst_10", 16'h0010, 1'b1, 16'h0100);
    reset = 1'b1; #1;
    check("arst_valid_o", 32'(valid_o), 32'd0);
    check("arst_hit_o",   32'(hit_o),   32'd0);
    check("arst_val_o",   32'(val_o),   32'd0);
    check("arst_count",   32'(count_o), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    do_read("post_rst_10", 16'h0010, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
